// File: rtl/sm2201_pkg.sv
// Shared constants and FSM encoding for the SM2201 ISA-to-CAMAC cycle controller.
package sm2201_pkg;

  localparam logic [9:0] BASE_ADDR     = 10'h100;
  localparam logic [7:0] TIMEOUT       = 8'd200;
  localparam logic [5:0] STATUS_OFFSET = 6'h3E;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_WAIT_INH = 2'd1;
  localparam state_t ST_STROBE   = 2'd2;
  localparam state_t ST_DONE     = 2'd3;

endpackage

// File: rtl/sm2201_cycle_timer.sv
// Saturating wait counter for one CAMAC cycle; expired once it reaches TIMEOUT.
module sm2201_cycle_timer #(
  parameter logic [7:0] TIMEOUT = 8'd200
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [7:0] count_q, count_d;

  assign expired_o = (count_q == TIMEOUT);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = 8'd0;
    end else if (enable_i && !expired_o) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sm2201_cycle_controller.sv
// ISA I/O window bridged onto 16-bit CAMAC word cycles, with byte assembly,
// wait-state insertion and a sticky timeout flag.
module sm2201_cycle_controller #(
  parameter logic [9:0] BASE_ADDR = sm2201_pkg::BASE_ADDR,
  parameter logic [7:0] TIMEOUT   = sm2201_pkg::TIMEOUT
) (
  input  logic        isa_clk,
  input  logic        isa_reset,
  input  logic [9:0]  isa_addr,
  input  logic        isa_ale,
  input  logic        isa_aen,
  input  logic        isa_ior,
  input  logic        isa_iow,
  input  logic [7:0]  isa_data_in,
  output logic [7:0]  isa_data_out,
  output logic        isa_data_oe,
  output logic        isa_chrdy,
  output logic [4:0]  cb_addr,
  output logic [15:0] cb_data_out,
  input  logic [15:0] cb_data_in,
  output logic        cb_data_oe,
  output logic        cb_strobe,
  output logic        cb_write,
  input  logic        cb_prr,
  input  logic        cb_zk4,
  output logic        timeout_err
);

  import sm2201_pkg::*;

  logic [9:0]  addr_q;
  logic        ior_q, iow_q;
  state_t      state_q, state_d;
  logic        chrdy_q, chrdy_d;
  logic        write_q, write_d;
  logic [7:0]  low_q, low_d;
  logic [15:0] rbuf_q, rbuf_d;
  logic [15:0] wdata_q, wdata_d;
  logic        terr_q, terr_d;
  logic        terr_set, terr_clr;

  logic [9:0]  offset_full;
  logic [5:0]  offset;
  logic        hit, is_status, rd_start, wr_start;
  logic        tmr_clear, tmr_en, tmr_expired;

  assign offset_full = addr_q - BASE_ADDR;
  assign offset      = offset_full[5:0];
  assign hit         = (addr_q >= BASE_ADDR) && (offset_full < 10'd64) && !isa_aen;
  assign is_status   = (offset >= STATUS_OFFSET);

  // A start is the clock on which the registered strobe is about to fall.
  assign rd_start = (state_q == ST_IDLE) && hit && ior_q && !isa_ior && isa_iow;
  assign wr_start = (state_q == ST_IDLE) && hit && iow_q && !isa_iow && isa_ior;

  assign tmr_clear = (state_q == ST_IDLE) && (state_d != ST_IDLE);
  assign tmr_en    = (state_q == ST_WAIT_INH) || (state_q == ST_STROBE);

  sm2201_cycle_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i     (isa_clk),
    .rst_ni    (isa_reset),
    .clear_i   (tmr_clear),
    .enable_i  (tmr_en),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d  = state_q;
    chrdy_d  = chrdy_q;
    write_d  = write_q;
    low_d    = low_q;
    rbuf_d   = rbuf_q;
    wdata_d  = wdata_q;
    terr_set = 1'b0;
    terr_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_start) begin
          if (is_status) begin
            terr_clr = 1'b1;
            state_d  = ST_DONE;
          end else if (!offset[0]) begin
            low_d   = isa_data_in;
            state_d = ST_DONE;
          end else begin
            wdata_d = {isa_data_in, low_q};
            write_d = 1'b1;
            chrdy_d = 1'b0;
            state_d = ST_WAIT_INH;
          end
        end else if (rd_start) begin
          if (is_status || offset[0]) begin
            state_d = ST_DONE;
          end else begin
            write_d = 1'b0;
            chrdy_d = 1'b0;
            state_d = ST_WAIT_INH;
          end
        end
      end
      ST_WAIT_INH: begin
        if (tmr_expired) begin
          terr_set = 1'b1;
        end else if (cb_zk4) begin
          state_d = ST_STROBE;
        end
      end
      ST_STROBE: begin
        if (!cb_prr) begin
          if (!write_q) begin
            rbuf_d = cb_data_in;
          end
          chrdy_d = 1'b1;
          state_d = ST_DONE;
        end else if (tmr_expired) begin
          terr_set = 1'b1;
        end
      end
      default: begin
        if (ior_q && iow_q) begin
          state_d = ST_IDLE;
        end
      end
    endcase
    if (terr_set) begin
      rbuf_d  = 16'hFFFF;
      chrdy_d = 1'b1;
      state_d = ST_DONE;
    end
    // A timeout on the same clock as a status-write clear keeps the flag set.
    terr_d = (terr_q && !terr_clr) || terr_set;
  end

  always_ff @(posedge isa_clk or negedge isa_reset) begin
    if (!isa_reset) begin
      addr_q  <= 10'd0;
      ior_q   <= 1'b1;
      iow_q   <= 1'b1;
      state_q <= ST_IDLE;
      chrdy_q <= 1'b1;
      write_q <= 1'b0;
      low_q   <= 8'h00;
      rbuf_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      terr_q  <= 1'b0;
    end else begin
      if (isa_ale) begin
        addr_q <= isa_addr;
      end
      ior_q   <= isa_ior;
      iow_q   <= isa_iow;
      state_q <= state_d;
      chrdy_q <= chrdy_d;
      write_q <= write_d;
      low_q   <= low_d;
      rbuf_q  <= rbuf_d;
      wdata_q <= wdata_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    if (offset == STATUS_OFFSET) begin
      isa_data_out = {7'b0, terr_q};
    end else if (is_status) begin
      isa_data_out = 8'h00;
    end else if (offset[0]) begin
      isa_data_out = rbuf_q[15:8];
    end else begin
      isa_data_out = rbuf_q[7:0];
    end
  end

  assign isa_data_oe = hit && !ior_q;
  assign isa_chrdy   = chrdy_q;
  assign cb_addr     = offset[5:1];
  assign cb_data_out = wdata_q;
  assign cb_strobe   = (state_q == ST_STROBE);
  assign cb_write    = write_q;
  assign cb_data_oe  = cb_strobe && write_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_sm2201_cycle_controller.sv
// Scoreboard bench: ISA bus master plus a CAMAC slave responder.
module tb_sm2201_cycle_controller;

  logic        isa_clk = 1'b0;
  logic        isa_reset = 1'b0;
  logic [9:0]  isa_addr = 10'd0;
  logic        isa_ale = 1'b0;
  logic        isa_aen = 1'b0;
  logic        isa_ior = 1'b1;
  logic        isa_iow = 1'b1;
  logic [7:0]  isa_data_in = 8'h00;
  logic [7:0]  isa_data_out;
  logic        isa_data_oe;
  logic        isa_chrdy;
  logic [4:0]  cb_addr;
  logic [15:0] cb_data_out;
  logic [15:0] cb_data_in = 16'h0000;
  logic        cb_data_oe;
  logic        cb_strobe;
  logic        cb_write;
  logic        cb_prr = 1'b1;
  logic        cb_zk4 = 1'b1;
  logic        timeout_err;

  sm2201_cycle_controller dut (
    .isa_clk(isa_clk), .isa_reset(isa_reset), .isa_addr(isa_addr), .isa_ale(isa_ale),
    .isa_aen(isa_aen), .isa_ior(isa_ior), .isa_iow(isa_iow), .isa_data_in(isa_data_in),
    .isa_data_out(isa_data_out), .isa_data_oe(isa_data_oe), .isa_chrdy(isa_chrdy),
    .cb_addr(cb_addr), .cb_data_out(cb_data_out), .cb_data_in(cb_data_in),
    .cb_data_oe(cb_data_oe), .cb_strobe(cb_strobe), .cb_write(cb_write),
    .cb_prr(cb_prr), .cb_zk4(cb_zk4), .timeout_err(timeout_err)
  );

  always #5 isa_clk = ~isa_clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] rd_q[$];

  // CAMAC slave state
  logic [15:0] slave_mem [32];
  int          prr_delay = 3;
  logic        prr_hold = 1'b0;
  int          strobe_cnt = 0;
  logic [4:0]  cap_addr;
  logic [15:0] cap_data;
  logic        cap_write;
  logic        cap_oe;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic seen;
    int   cyc;
    seen = 1'b0;
    cyc  = 0;
    for (int i = 0; i < 32; i++) slave_mem[i] = 16'h0000;
    forever begin
      @(negedge isa_clk);
      if (cb_strobe) begin
        if (!seen) begin
          seen = 1'b1;
          strobe_cnt++;
          cap_addr  = cb_addr;
          cap_write = cb_write;
          cap_data  = cb_data_out;
          cap_oe    = cb_data_oe;
          if (cb_write) slave_mem[cb_addr] = cb_data_out;
          cyc = 0;
        end
        cyc++;
        cb_data_in = slave_mem[cb_addr];
        if (!prr_hold && cyc >= prr_delay) cb_prr = 1'b0;
      end else begin
        seen   = 1'b0;
        cb_prr = 1'b1;
      end
    end
  end

  // mode: 0 read, 1 write, 2 both strobes low
  task automatic isa_io(input int mode, input logic [9:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output logic oe,
                        output int waited, output logic dropped);
    @(negedge isa_clk);
    isa_addr    = a;
    isa_ale     = 1'b1;
    isa_data_in = d;
    @(negedge isa_clk);
    isa_ale = 1'b0;
    @(negedge isa_clk);
    if (mode != 1) isa_ior = 1'b0;
    if (mode != 0) isa_iow = 1'b0;
    waited  = 0;
    dropped = 1'b0;
    @(negedge isa_clk);
    while (!isa_chrdy && waited < 400) begin
      dropped = 1'b1;
      waited++;
      @(negedge isa_clk);
    end
    check_val("chrdy_release", {31'b0, isa_chrdy}, 32'd1);
    rd = isa_data_out;
    oe = isa_data_oe;
    $display("io mode=%0d addr=%03h din=%02h dout=%02h oe=%0b wait=%0d", mode, a, d, rd, oe, waited);
    isa_ior = 1'b1;
    isa_iow = 1'b1;
    repeat (3) @(negedge isa_clk);
  endtask

  task automatic do_write(input logic [9:0] a, input logic [7:0] d, input string tag,
                          input int exp_strobes, input logic exp_drop);
    logic [7:0] rd;
    logic oe, dropped;
    int waited, s0;
    s0 = strobe_cnt;
    isa_io(1, a, d, rd, oe, waited, dropped);
    check_val({tag, "_strobes"}, strobe_cnt - s0, exp_strobes);
    check_val({tag, "_chrdy_drop"}, {31'b0, dropped}, {31'b0, exp_drop});
  endtask

  task automatic do_read(input logic [9:0] a, input logic [7:0] exp, input string tag,
                         input int exp_strobes);
    logic [7:0] rd, e;
    logic oe, dropped;
    int waited, s0;
    s0 = strobe_cnt;
    rd_q.push_back(exp);
    isa_io(0, a, 8'h00, rd, oe, waited, dropped);
    e = rd_q.pop_front();
    check_val({tag, "_data"}, rd, e);
    check_val({tag, "_oe"}, {31'b0, oe}, 32'd1);
    check_val({tag, "_strobes"}, strobe_cnt - s0, exp_strobes);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic oe, dropped;
    int waited, s0;

    slave_mem[1] = 16'h4208;
    repeat (3) @(negedge isa_clk);
    check_val("rst_chrdy", {31'b0, isa_chrdy}, 32'd1);
    check_val("rst_strobe", {31'b0, cb_strobe}, 32'd0);
    check_val("rst_write", {31'b0, cb_write}, 32'd0);
    check_val("rst_cb_oe", {31'b0, cb_data_oe}, 32'd0);
    check_val("rst_isa_oe", {31'b0, isa_data_oe}, 32'd0);
    check_val("rst_terr", {31'b0, timeout_err}, 32'd0);
    isa_reset = 1'b1;
    repeat (2) @(negedge isa_clk);

    // byte assembly then word write
    do_write(10'h100, 8'h08, "wr_lo", 0, 1'b0);
    do_write(10'h101, 8'h42, "wr_hi", 1, 1'b1);
    check_val("wr_hi_addr", cap_addr, 32'd0);
    check_val("wr_hi_data", cap_data, 32'h4208);
    check_val("wr_hi_dir", {31'b0, cap_write}, 32'd1);
    check_val("wr_hi_cboe", {31'b0, cap_oe}, 32'd1);

    // word read with 5-clock slave response, then high byte from buffer
    prr_delay = 5;
    do_read(10'h102, 8'h08, "rd_lo", 1);
    check_val("rd_lo_addr", cap_addr, 32'd1);
    check_val("rd_lo_dir", {31'b0, cap_write}, 32'd0);
    check_val("rd_lo_cboe", {31'b0, cap_oe}, 32'd0);
    do_read(10'h103, 8'h42, "rd_hi", 0);
    do_read(10'h100, 8'h08, "rd_w0", 1);
    prr_delay = 3;

    // timeout path
    prr_hold = 1'b1;
    s0 = strobe_cnt;
    rd_q.push_back(8'hFF);
    isa_io(0, 10'h104, 8'h00, rd, oe, waited, dropped);
    check_val("to_data", rd, rd_q.pop_front());
    check_val("to_wait_range", {31'b0, (waited >= 190 && waited <= 215)}, 32'd1);
    check_val("to_strobes", strobe_cnt - s0, 32'd1);
    check_val("to_terr", {31'b0, timeout_err}, 32'd1);
    prr_hold = 1'b0;
    do_read(10'h105, 8'hFF, "to_hi", 0);
    do_read(10'h13E, 8'h01, "stat_set", 0);
    do_read(10'h13F, 8'h00, "stat_3f", 0);
    do_write(10'h13E, 8'h00, "stat_clr", 0, 1'b0);
    check_val("stat_clr_terr", {31'b0, timeout_err}, 32'd0);
    do_read(10'h13E, 8'h00, "stat_clear", 0);

    // inhibit holds off the strobe
    do_write(10'h106, 8'h3C, "zk_lo", 0, 1'b0);
    cb_zk4 = 1'b0;
    s0 = strobe_cnt;
    fork
      isa_io(1, 10'h107, 8'hA5, rd, oe, waited, dropped);
      begin
        repeat (12) @(negedge isa_clk);
        check_val("zk_hold_strobe", {31'b0, cb_strobe}, 32'd0);
        check_val("zk_hold_chrdy", {31'b0, isa_chrdy}, 32'd0);
        cb_zk4 = 1'b1;
        @(negedge isa_clk);
        check_val("zk_rel_strobe", {31'b0, cb_strobe}, 32'd1);
      end
    join
    check_val("zk_strobes", strobe_cnt - s0, 32'd1);
    check_val("zk_addr", cap_addr, 32'd3);
    check_val("zk_data", cap_data, 32'hA53C);

    // cycles not for this window
    isa_aen = 1'b1;
    do_write(10'h100, 8'h99, "aen_lo", 0, 1'b0);
    do_write(10'h101, 8'h55, "aen_hi", 0, 1'b0);
    isa_io(0, 10'h102, 8'h00, rd, oe, waited, dropped);
    check_val("aen_rd_oe", {31'b0, oe}, 32'd0);
    isa_aen = 1'b0;
    do_write(10'h140, 8'h77, "miss_wr", 0, 1'b0);
    do_write(10'h101, 8'h11, "wr_after", 1, 1'b1);
    check_val("wr_after_data", cap_data, 32'h113C);
    check_val("wr_after_addr", cap_addr, 32'd0);

    // both strobes low together
    s0 = strobe_cnt;
    isa_io(2, 10'h101, 8'hEE, rd, oe, waited, dropped);
    check_val("both_strobes", strobe_cnt - s0, 32'd0);
    check_val("both_drop", {31'b0, dropped}, 32'd0);

    // asynchronous reset during STROBE
    prr_hold = 1'b1;
    @(negedge isa_clk);
    isa_addr = 10'h108;
    isa_ale  = 1'b1;
    @(negedge isa_clk);
    isa_ale = 1'b0;
    @(negedge isa_clk);
    isa_ior = 1'b0;
    waited = 0;
    while (!cb_strobe && waited < 20) begin
      waited++;
      @(negedge isa_clk);
    end
    check_val("mid_strobe_up", {31'b0, cb_strobe}, 32'd1);
    #2 isa_reset = 1'b0;
    #1;
    check_val("mid_rst_strobe", {31'b0, cb_strobe}, 32'd0);
    check_val("mid_rst_chrdy", {31'b0, isa_chrdy}, 32'd1);
    check_val("mid_rst_cboe", {31'b0, cb_data_oe}, 32'd0);
    isa_ior  = 1'b1;
    prr_hold = 1'b0;
    @(negedge isa_clk);
    @(negedge isa_clk);
    isa_reset = 1'b1;
    @(negedge isa_clk);
    do_read(10'h102, 8'h08, "post_rst", 1);
    do_read(10'h103, 8'h42, "post_rst_hi", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
